// File: rtl/pcore_divide_pkg.sv
// -----------------------------------------------------------------------------
// pcore_divide_pkg
// Shared types and constants for the RV32M divide unit: the execute->divider
// request struct, the divide op encoding, the divider FSM state type and the
// signed-overflow dividend constant (most negative XLEN-bit value).
// -----------------------------------------------------------------------------
package pcore_divide_pkg;

    localparam int DIV_XLEN = 32;

    // Most negative dividend; divided by -1 it overflows the signed range.
    localparam logic [DIV_XLEN-1:0] DIV_OVF_DIVIDEND = {1'b1, {(DIV_XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        ALU_D_OPS_NONE,
        ALU_D_OPS_DIV,
        ALU_D_OPS_DIVU,
        ALU_D_OPS_REM,
        ALU_D_OPS_REMU
    } type_alu_d_ops_e;

    typedef struct packed {
        type_alu_d_ops_e       alu_d_ops;
        logic [DIV_XLEN-1:0]   rs1_data;   // dividend
        logic [DIV_XLEN-1:0]   rs2_data;   // divisor
    } type_exe2div_s;

    typedef enum logic [1:0] {
        DIV_ST_IDLE,
        DIV_ST_CALC,
        DIV_ST_SPECIAL,
        DIV_ST_DONE
    } type_div_state_e;

endpackage

// File: rtl/pcore_div_sign_fix.sv
// -----------------------------------------------------------------------------
// pcore_div_sign_fix
// Combinational conditional two's-complement negate. Used both to take the
// magnitude of signed operands on entry and to restore the sign of the
// quotient/remainder on exit. The most negative value maps to itself, which
// read as unsigned is exactly its magnitude.
// Ports:
//   i_val  in  W  value
//   i_neg  in  1  negate when 1
//   o_val  out W  i_neg ? -i_val : i_val
// -----------------------------------------------------------------------------
module pcore_div_sign_fix
    import pcore_divide_pkg::*;
#(
    parameter int W = DIV_XLEN
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? ((~i_val) + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/pcore_divide.sv
// -----------------------------------------------------------------------------
// pcore_divide
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU. One divide in
// flight; execute holds the request stable while div2exe_busy_o is high.
// Normal ops take XLEN+1 cycles from accept to valid, divide-by-zero and
// signed overflow take 2 cycles.
// Optional feature (macro PCORE_DIV_REUSE_EN): remembers the last completed
// operands and results so a matching follow-up op (DIV then REM of the same
// operands) completes in 1 cycle.
// Ports:
//   clk               in   clock
//   rst               in   synchronous active-high reset
//   exe2div_i         in   op, dividend (rs1_data), divisor (rs2_data)
//   flush_i           in   kill current/pending divide
//   div2exe_busy_o    out  stall execute
//   div2lsu_valid_o   out  one-cycle result valid
//   div2lsu_result_o  out  quotient or remainder, held after valid drops
// -----------------------------------------------------------------------------
module pcore_divide
    import pcore_divide_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  type_exe2div_s   exe2div_i,
    input  logic            flush_i,
    output logic            div2exe_busy_o,
    output logic            div2lsu_valid_o,
    output logic [XLEN-1:0] div2lsu_result_o
);

    type_div_state_e r_state, w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_dq;        // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_dsr;       // divisor magnitude
    logic [XLEN-1:0]  r_dvd_raw;   // raw dividend, the divide-by-zero remainder
    logic             r_neg_q, r_neg_r, r_is_rem, r_div0;
    logic [XLEN-1:0]  r_result;

    // Request decode
    logic [XLEN-1:0] w_dvd, w_dsr, w_dvd_abs, w_dsr_abs;
    logic            w_has_op, w_signed, w_is_rem, w_dvd_neg, w_dsr_neg;
    logic            w_div0, w_special, w_reuse_hit, w_accept, w_finish, w_busy;

    assign w_dvd     = exe2div_i.rs1_data;
    assign w_dsr     = exe2div_i.rs2_data;
    assign w_has_op  = (exe2div_i.alu_d_ops != ALU_D_OPS_NONE);
    assign w_signed  = (exe2div_i.alu_d_ops == ALU_D_OPS_DIV) || (exe2div_i.alu_d_ops == ALU_D_OPS_REM);
    assign w_is_rem  = (exe2div_i.alu_d_ops == ALU_D_OPS_REM) || (exe2div_i.alu_d_ops == ALU_D_OPS_REMU);
    assign w_dvd_neg = w_signed && w_dvd[XLEN-1];
    assign w_dsr_neg = w_signed && w_dsr[XLEN-1];
    assign w_div0    = (w_dsr == '0);
    assign w_special = w_div0 || (w_signed && (w_dvd == DIV_OVF_DIVIDEND) && (w_dsr == '1));

    pcore_div_sign_fix #(.W(XLEN)) u_dvd_abs (.i_val(w_dvd), .i_neg(w_dvd_neg), .o_val(w_dvd_abs));
    pcore_div_sign_fix #(.W(XLEN)) u_dsr_abs (.i_val(w_dsr), .i_neg(w_dsr_neg), .o_val(w_dsr_abs));

    // One restoring step. The partial remainder is carried at XLEN+1 bits so
    // unsigned divisors with the MSB set still compare correctly.
    logic [XLEN:0]   w_rem_sh, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt, w_dq_nxt, w_q_fix, w_r_fix;

    assign w_rem_sh  = {r_rem, r_dq[XLEN-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dsr};
    assign w_ge      = ~w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_dq_nxt  = {r_dq[XLEN-2:0], w_ge};

    pcore_div_sign_fix #(.W(XLEN)) u_q_fix (.i_val(w_dq_nxt),  .i_neg(r_neg_q), .o_val(w_q_fix));
    pcore_div_sign_fix #(.W(XLEN)) u_r_fix (.i_val(w_rem_nxt), .i_neg(r_neg_r), .o_val(w_r_fix));

    // Final quotient/remainder on the cycle that enters DONE
    logic [XLEN-1:0] w_q_done, w_r_done;
    assign w_q_done = (r_state == DIV_ST_SPECIAL) ? (r_div0 ? '1 : DIV_OVF_DIVIDEND) : w_q_fix;
    assign w_r_done = (r_state == DIV_ST_SPECIAL) ? (r_div0 ? r_dvd_raw : '0)      : w_r_fix;

`ifdef PCORE_DIV_REUSE_EN
    logic            r_signed, r_lst_sgn, r_lst_vld;
    logic [XLEN-1:0] r_dsr_raw, r_lst_dvd, r_lst_dsr, r_lst_q, r_lst_r;
    assign w_reuse_hit = r_lst_vld && (r_lst_dvd == w_dvd) && (r_lst_dsr == w_dsr) && (r_lst_sgn == w_signed);
`else
    assign w_reuse_hit = 1'b0;
`endif

    // Next state / busy
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            DIV_ST_IDLE: begin
                if (w_has_op && !flush_i) begin
                    w_busy   = 1'b1;
                    w_accept = 1'b1;
                    if (w_reuse_hit)    w_state_nxt = DIV_ST_DONE;
                    else if (w_special) w_state_nxt = DIV_ST_SPECIAL;
                    else                w_state_nxt = DIV_ST_CALC;
                end
            end
            DIV_ST_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == '0) w_state_nxt = DIV_ST_DONE;
            end
            DIV_ST_SPECIAL: begin
                w_busy      = 1'b1;
                w_state_nxt = DIV_ST_DONE;
            end
            default: w_state_nxt = DIV_ST_IDLE;
        endcase
        if (flush_i) w_state_nxt = DIV_ST_IDLE;
        if (rst)     w_busy      = 1'b0;
    end

    assign w_finish = !flush_i && (((r_state == DIV_ST_CALC) && (r_cnt == '0)) || (r_state == DIV_ST_SPECIAL));

    always_ff @(posedge clk) begin
        if (rst) r_state <= DIV_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_dq      <= '0;
            r_rem     <= '0;
            r_dsr     <= '0;
            r_dvd_raw <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_is_rem  <= 1'b0;
            r_div0    <= 1'b0;
            r_result  <= '0;
`ifdef PCORE_DIV_REUSE_EN
            r_signed  <= 1'b0;
            r_dsr_raw <= '0;
            r_lst_sgn <= 1'b0;
            r_lst_vld <= 1'b0;
            r_lst_dvd <= '0;
            r_lst_dsr <= '0;
            r_lst_q   <= '0;
            r_lst_r   <= '0;
`endif
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_dq      <= w_dvd_abs;
                r_rem     <= '0;
                r_dsr     <= w_dsr_abs;
                r_dvd_raw <= w_dvd;
                r_neg_q   <= w_dvd_neg ^ w_dsr_neg;
                r_neg_r   <= w_dvd_neg;
                r_is_rem  <= w_is_rem;
                r_div0    <= w_div0;
                if (!w_reuse_hit && !w_special) r_cnt <= CNT_W'(XLEN-1);
`ifdef PCORE_DIV_REUSE_EN
                r_signed  <= w_signed;
                r_dsr_raw <= w_dsr;
                if (w_reuse_hit) r_result <= w_is_rem ? r_lst_r : r_lst_q;
`endif
            end
            if (r_state == DIV_ST_CALC) begin
                r_dq  <= w_dq_nxt;
                r_rem <= w_rem_nxt;
                if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_finish) begin
                r_result <= r_is_rem ? w_r_done : w_q_done;
`ifdef PCORE_DIV_REUSE_EN
                r_lst_vld <= 1'b1;
                r_lst_sgn <= r_signed;
                r_lst_dvd <= r_dvd_raw;
                r_lst_dsr <= r_dsr_raw;
                r_lst_q   <= w_q_done;
                r_lst_r   <= w_r_done;
`endif
            end
        end
    end

    assign div2exe_busy_o   = w_busy;
    assign div2lsu_valid_o  = (r_state == DIV_ST_DONE);
    assign div2lsu_result_o = r_result;

endmodule

// File: tb/tb_pcore_divide.sv
module tb_pcore_divide;
    import pcore_divide_pkg::*;

    logic          clk;
    logic          rst;
    logic          flush;
    type_exe2div_s exe2div;
    logic          busy;
    logic          valid;
    logic [31:0]   result;

    int total = 0;
    int bad   = 0;

`ifdef PCORE_DIV_REUSE_EN
    localparam bit REUSE_ON = 1'b1;
`else
    localparam bit REUSE_ON = 1'b0;
`endif

    // Reference model state for the reuse feature: last completed request
    logic [31:0] last_a, last_b;
    bit          last_sgn, last_vld;

    pcore_divide dut (
        .clk              (clk),
        .rst              (rst),
        .exe2div_i        (exe2div),
        .flush_i          (flush),
        .div2exe_busy_o   (busy),
        .div2lsu_valid_o  (valid),
        .div2lsu_result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_signed_op(input type_alu_d_ops_e op);
        return (op == ALU_D_OPS_DIV) || (op == ALU_D_OPS_REM);
    endfunction

    // RISC-V M semantics from plain 64-bit arithmetic (truncating division).
    function automatic logic [31:0] ref_div(input type_alu_d_ops_e op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ALU_D_OPS_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_D_OPS_REMU: return (b == 0) ? a : a % b;
            ALU_D_OPS_DIV:  return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            ALU_D_OPS_REM:  return (b == 0) ? a : 32'(sa % sb);
            default:        return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input type_alu_d_ops_e op, input logic [31:0] a, input logic [31:0] b);
        bit sgn;
        sgn = is_signed_op(op);
        if (REUSE_ON && last_vld && last_a == a && last_b == b && last_sgn == sgn) return 1;
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        return 33;
    endfunction

    // Present one op, wait for its result, check value/latency/busy/pulse.
    task automatic run_op(input type_alu_d_ops_e op, input logic [31:0] a, input logic [31:0] b,
                          input string nm, input bit scramble);
        logic [31:0] exp;
        int          exp_lat, cyc, busy_n;
        exp     = ref_div(op, a, b);
        exp_lat = ref_lat(op, a, b);
        exe2div.alu_d_ops = op;
        exe2div.rs1_data  = a;
        exe2div.rs2_data  = b;
        #1;
        busy_n = (busy === 1'b1) ? 1 : 0;
        cyc    = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (valid === 1'b1 || cyc > 100) break;
            if (busy === 1'b1) busy_n++;
            if (scramble && cyc == 5) begin
                exe2div.rs1_data = $urandom;
                exe2div.rs2_data = $urandom;
            end
        end
        total++;
        if (valid !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: valid=%b after %0d cycles, want 1", nm, valid, cyc);
        end
        total++;
        if (result !== exp) begin
            bad++;
            $display("FAIL %s_result: got %h want %h", nm, result, exp);
        end
        total++;
        if (cyc != exp_lat) begin
            bad++;
            $display("FAIL %s_latency: got %0d want %0d", nm, cyc, exp_lat);
        end
        total++;
        if (busy_n != exp_lat || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy: busy cycles %0d (busy at valid %b) want %0d (0)", nm, busy_n, busy, exp_lat);
        end
        exe2div.alu_d_ops = ALU_D_OPS_NONE;
        last_vld = 1'b1;
        last_a   = a;
        last_b   = b;
        last_sgn = is_signed_op(op);
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b0 || result !== exp) begin
            bad++;
            $display("FAIL %s_pulse: valid=%b result=%h want valid=0 result=%h", nm, valid, result, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        exe2div = '0;
        last_vld = 1'b0;
        last_a = '0; last_b = '0; last_sgn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: valid=%b result=%h busy=%b want 0/0/0", valid, result, busy);
        end
        exe2div.alu_d_ops = ALU_D_OPS_DIVU;
        exe2div.rs1_data  = 32'd5;
        exe2div.rs2_data  = 32'd1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy: busy=%b want 0 while rst", busy);
        end
        exe2div.alu_d_ops = ALU_D_OPS_NONE;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: valid=%b busy=%b want 0/0", valid, busy);
        end
    endtask

    task automatic test_directed();
        run_op(ALU_D_OPS_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b0);
        run_op(ALU_D_OPS_REMU, 32'd100, 32'd7, "remu_100_7", 1'b0);
        run_op(ALU_D_OPS_DIV,  32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
        run_op(ALU_D_OPS_REM,  32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b0);
        run_op(ALU_D_OPS_REM,  32'd7, 32'hFFFF_FFFE, "rem_7_m2", 1'b0);
        run_op(ALU_D_OPS_DIV,  32'd5, 32'd0, "div_5_0", 1'b0);
        run_op(ALU_D_OPS_REMU, 32'd5, 32'd0, "remu_5_0", 1'b0);
        run_op(ALU_D_OPS_REM,  32'd5, 32'd0, "rem_5_0", 1'b0);
        run_op(ALU_D_OPS_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        run_op(ALU_D_OPS_REM,  32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        run_op(ALU_D_OPS_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, "divu_big", 1'b0);
        run_op(ALU_D_OPS_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "remu_big", 1'b0);
        run_op(ALU_D_OPS_DIV,  32'h8000_0000, 32'd3, "div_minint_3", 1'b0);
    endtask

    task automatic test_random();
        type_alu_d_ops_e op;
        logic [31:0]     a, b;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0:       op = ALU_D_OPS_DIV;
                1:       op = ALU_D_OPS_DIVU;
                2:       op = ALU_D_OPS_REM;
                default: op = ALU_D_OPS_REMU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = 32'h0 - 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b, "random", 1'b0);
        end
    endtask

    task automatic test_flush();
        int pulses;
        exe2div.alu_d_ops = ALU_D_OPS_DIVU;
        exe2div.rs1_data  = 32'd1000;
        exe2div.rs2_data  = 32'd3;
        repeat (11) begin @(posedge clk); #1; end
        flush = 1'b1;
        exe2div.alu_d_ops = ALU_D_OPS_NONE;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle: busy=%b valid=%b want 0/0", busy, valid);
        end
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL flush_no_result: got %0d valid pulses want 0", pulses);
        end
        run_op(ALU_D_OPS_DIVU, 32'd9, 32'd3, "after_flush", 1'b0);
    endtask

    task automatic test_rst_mid();
        logic [31:0] a, b;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        exe2div.alu_d_ops = ALU_D_OPS_DIV;
        exe2div.rs1_data  = a;
        exe2div.rs2_data  = b;
        repeat (15) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_busy: busy=%b want 0 while rst", busy);
        end
        @(posedge clk); #1;
        total++;
        if (valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear: valid=%b result=%h busy=%b want 0/0/0", valid, result, busy);
        end
        rst = 1'b0;
        last_vld = 1'b0;
        run_op(ALU_D_OPS_DIV, a, b, "rst_fresh", 1'b0);
    endtask

    task automatic test_operand_change();
        run_op(ALU_D_OPS_DIVU, 32'd123456, 32'd789, "opchg_divu", 1'b1);
        run_op(ALU_D_OPS_DIV,  32'hFFFF_0000, 32'd77, "opchg_div", 1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(ALU_D_OPS_DIV, 32'd100, 32'd7, "b2b_div", 1'b0);
        run_op(ALU_D_OPS_REM, 32'd100, 32'd7, "b2b_rem", 1'b0);
        run_op(ALU_D_OPS_REMU, 32'd100, 32'd7, "b2b_remu", 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_rst_mid();
        test_operand_change();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
